mem_bank_responder: RTL
=======================

Name: mem_bank_responder

Overview:
- Memory-side end of the BIST/BISR memory interface: accepts the registered MEM_* command bus issued by the BIST/memory controller and returns read data on BIST_ODATA one cycle later.
- Models an NBANK x DEPTH x DW banked SRAM with a single-word spare (repair) register and a programmable stuck-at fault injector.
- Lets the BIST/BISR loop detect, report and repair a defective word end to end.
- Synthesizable; serves as the memory stand-in in block-level and system simulation.

Parameters:
- NBANK, 64, number of banks; width of MEM_CSB/MEM_OEB.
- AW, 10, word address width; DEPTH = 2**AW.
- DW, 8, data width.
- SW, 6, bank-select width; log2(NBANK).

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- MEM_ADDR  in  AW  word address
- MEM_CE  in  1  access enable, active high
- MEM_WEB  in  1  0 = write, 1 = read
- MEM_OEB  in  NBANK  per-bank output enable, active low
- MEM_CSB  in  NBANK  per-bank chip select, active low
- MEM_IDATA  in  DW  write data
- MEM_ODATA_SELECT  in  SW  bank index expected on read return
- FAULT_EN  in  1  enable stuck-at injection
- FAULT_ADDR  in  AW  faulty word address
- FAULT_SELECT  in  SW  faulty bank
- FAULT_BIT  in  3  faulty bit index (< DW)
- FAULT_VAL  in  1  stuck value
- REPAIR_EN  in  1  enable spare-word redirection
- REPAIR_ADDR  in  AW  repaired word address
- REPAIR_SELECT  in  SW  repaired bank
- BIST_ODATA  out  DW  read data
- RVALID  out  1  BIST_ODATA holds data from the previous cycle's read
- PROTO_ERR  out  1  sticky protocol-violation flag

Behaviour:
- Reset (RSTN low, async): BIST_ODATA=0, RVALID=0, PROTO_ERR=0, spare word=0. Array contents are not reset.
- Bank decode: the selected bank b is the index of the single 0 bit in MEM_CSB. Active bit count k = number of 0 bits in MEM_CSB.
- An access occurs only when MEM_CE=1 and k=1.
- MEM_CE=1 with k=0 or k>1:
  - No array or spare update.
  - RVALID=0, BIST_ODATA holds.
  - PROTO_ERR set if k>1.
- MEM_CE=0: idle regardless of CSB/OEB. RVALID=0 next cycle, BIST_ODATA holds.
- Write (access, MEM_WEB=0):
  - At the clock edge, MEM_IDATA is stored to mem[b][MEM_ADDR].
  - If REPAIR_EN=1 and (b,MEM_ADDR)==(REPAIR_SELECT,REPAIR_ADDR), the write goes to the spare word instead and the array is untouched.
  - RVALID=0 next cycle.
- Read (access, MEM_WEB=1):
  - If MEM_OEB[b]=1: no data. RVALID=0, BIST_ODATA holds.
  - If MEM_OEB[b]=0: latency 1. At the edge, BIST_ODATA <= rdata and RVALID <= 1.
  - rdata source: spare word if the repair condition matches, otherwise mem[b][MEM_ADDR].
  - If FAULT_EN=1, the repair condition does not match, and (b,MEM_ADDR)==(FAULT_SELECT,FAULT_ADDR): rdata bit FAULT_BIT is forced to FAULT_VAL. The fault is read-side only; stored data is not altered.
  - If MEM_ODATA_SELECT != b: BIST_ODATA <= 0, RVALID <= 1, and PROTO_ERR is set.
- Priority: repair overrides fault. Write and read never coincide, since MEM_WEB selects one.
- FAULT_BIT >= DW: the fault has no effect.
- Back-to-back accesses are allowed every cycle. A read of an address written in the previous cycle returns the new data (array write completes at that edge).
- PROTO_ERR clears only on reset.
- Reset mid-operation: outputs return to reset values immediately. The array keeps its contents. The spare word is cleared.
- Address wrap: none needed. MEM_ADDR is always < DEPTH by width.

Test Plan:
- Write/read, clean: write 0xA5 to bank 3, addr 0x010 (CSB bit3=0, WEB=0); next cycle read with OEB bit3=0, ODATA_SELECT=3 → following cycle BIST_ODATA=0xA5, RVALID=1, PROTO_ERR=0.
- Stuck-at detection: FAULT_EN=1, FAULT_SELECT=5, FAULT_ADDR=0x3FF, FAULT_BIT=0, FAULT_VAL=1; write 0x00 there, read back → BIST_ODATA=0x01. Read bank 5 addr 0x3FE (written 0x00) → 0x00.
- Repair: same fault plus REPAIR_EN=1, REPAIR_SELECT=5, REPAIR_ADDR=0x3FF; write 0x00, read → BIST_ODATA=0x00. Repeat with 0xFF → 0xFF. Verify bank 5 addr 0x3FF in the array is unchanged by reading after REPAIR_EN=0 (faulted value returned).
- Protocol errors: MEM_CE=1 with CSB bits 1 and 2 both low, WEB=0 → no write to either bank, PROTO_ERR=1 and it stays 1. Separately, read bank 7 with ODATA_SELECT=6 → BIST_ODATA=0x00, RVALID=1, PROTO_ERR=1.
- Idle/OEB gating: read with OEB[b]=1 → RVALID=0 and BIST_ODATA holds its prior value. MEM_CE=0 with CSB all low → no access, RVALID=0.
- Async reset mid-stream: assert RSTN=0 between clock edges during a read burst → BIST_ODATA=0, RVALID=0, PROTO_ERR=0 immediately. After release, reading a previously written word (no repair) returns its stored value. A previously repaired word reads 0x00 (spare cleared).

Source files
------------

// File: rtl/mem_bank_responder.sv
// mem_bank_responder: banked SRAM stand-in for the BIST/BISR loop,
// with one spare word and a read-side stuck-at fault injector.
module mem_bank_responder #(
  parameter int NBANK = 64,
  parameter int AW    = 10,
  parameter int DW    = 8,
  parameter int SW    = 6
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [AW-1:0]    MEM_ADDR,
  input  logic             MEM_CE,
  input  logic             MEM_WEB,
  input  logic [NBANK-1:0] MEM_OEB,
  input  logic [NBANK-1:0] MEM_CSB,
  input  logic [DW-1:0]    MEM_IDATA,
  input  logic [SW-1:0]    MEM_ODATA_SELECT,
  input  logic             FAULT_EN,
  input  logic [AW-1:0]    FAULT_ADDR,
  input  logic [SW-1:0]    FAULT_SELECT,
  input  logic [2:0]       FAULT_BIT,
  input  logic             FAULT_VAL,
  input  logic             REPAIR_EN,
  input  logic [AW-1:0]    REPAIR_ADDR,
  input  logic [SW-1:0]    REPAIR_SELECT,
  output logic [DW-1:0]    BIST_ODATA,
  output logic             RVALID,
  output logic             PROTO_ERR
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [NBANK][DEPTH];
  logic [DW-1:0] spare;

  logic [SW:0]   k;
  logic [SW-1:0] b;
  logic          acc;
  logic          multi;
  logic          wr;
  logic          rd;
  logic          oe;
  logic          sel_ok;
  logic          rep_hit;
  logic          flt_hit;
  logic [DW-1:0] rdata;

  always_comb begin
    k = '0;
    b = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (!MEM_CSB[i]) begin
        k = k + 1'b1;
        b = SW'(i);
      end
    end
  end

  assign acc    = MEM_CE && (k == {{SW{1'b0}}, 1'b1});
  assign multi  = MEM_CE && (k > {{SW{1'b0}}, 1'b1});
  assign wr     = acc && !MEM_WEB;
  assign rd     = acc && MEM_WEB;
  assign oe     = !MEM_OEB[b];
  assign sel_ok = (MEM_ODATA_SELECT == b);

  assign rep_hit = REPAIR_EN
                && (b == REPAIR_SELECT)
                && (MEM_ADDR == REPAIR_ADDR);

  // Repair wins: a redirected word never shows the injected fault.
  assign flt_hit = FAULT_EN && !rep_hit
                && (b == FAULT_SELECT)
                && (MEM_ADDR == FAULT_ADDR)
                && (int'(FAULT_BIT) < DW);

  always_comb begin
    rdata = rep_hit ? spare : mem[b][MEM_ADDR];
    if (flt_hit) rdata[FAULT_BIT] = FAULT_VAL;
  end

  always_ff @(posedge CLK) begin
    if (wr && !rep_hit) mem[b][MEM_ADDR] <= MEM_IDATA;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      BIST_ODATA <= '0;
      RVALID     <= 1'b0;
      PROTO_ERR  <= 1'b0;
      spare      <= '0;
    end else begin
      RVALID <= 1'b0;
      if (multi) PROTO_ERR <= 1'b1;
      if (wr && rep_hit) spare <= MEM_IDATA;
      if (rd && oe) begin
        RVALID <= 1'b1;
        if (sel_ok) begin
          BIST_ODATA <= rdata;
        end else begin
          BIST_ODATA <= '0;
          PROTO_ERR  <= 1'b1;
        end
      end
    end
  end

endmodule
